// File: rtl/shift_pipe_if.sv
// shift_pipe_if: handshake/data bundle for the shift_pipe pipelined shifter.
//   Flush     - synchronous squash of all in-flight operations
//   InValid   - operation presented on the input side
//   InReady   - shifter accepts the presented operation this cycle
//   ValueIn   - operand word
//   Shamt     - shift amount, 0..DATA_W-1
//   Mode      - 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   OutValid  - result present
//   OutReady  - downstream accepts the result
//   ValueOut  - shifted result
//   ZeroOut   - ValueOut == 0 (meaningful while OutValid)
// master: the side that issues operations and consumes results.
// slave:  the shifter itself.
interface shift_pipe_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               Flush;
  logic               InValid;
  logic               InReady;
  logic [DATA_W-1:0]  ValueIn;
  logic [SHAMT_W-1:0] Shamt;
  logic [1:0]         Mode;
  logic               OutValid;
  logic               OutReady;
  logic [DATA_W-1:0]  ValueOut;
  logic               ZeroOut;

  modport master (
    output Flush, InValid, ValueIn, Shamt, Mode, OutReady,
    input  InReady, OutValid, ValueOut, ZeroOut
  );

  modport slave (
    input  Flush, InValid, ValueIn, Shamt, Mode, OutReady,
    output InReady, OutValid, ValueOut, ZeroOut
  );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined shifter (SLL, SRL, SRA, ROTR) with
// valid/ready handshake on both sides and a synchronous flush.
//   Clk     - rising-edge clock
//   Reset_n - asynchronous, active-low reset
//   sp      - shift_pipe_if slave port (operand/amount/mode in, result out)
// Stage 1 performs the coarse shift (amount rounded down to a multiple of 4)
// and carries the residual 2-bit amount, mode and operand sign bit.
// Stage 2 applies the residual 0..3 shift and registers the result.
module shift_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic         Clk,
  input  logic         Reset_n,
  shift_pipe_if.slave  sp
);

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTR = 2'b11
  } mode_e;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] amt_t;

  // Shifting in two pieces composes exactly for every mode: the arithmetic
  // fill uses the original operand sign rather than the stage-1 MSB, and a
  // rotate by a+b equals rotate by a followed by rotate by b.
  function automatic word_t shift_word(
    input word_t v,
    input amt_t  amt,
    input mode_e mode,
    input logic  sign
  );
    word_t ones;
    word_t fill;
    amt_t  back;
    word_t r;
    ones = '1;
    fill = sign ? ~(ones >> amt) : '0;
    // Rotate left-back amount is (DATA_W - amt) mod DATA_W; amt = 0 yields 0,
    // so both halves are v and the OR returns v unchanged.
    back = -amt;
    case (mode)
      MODE_SLL: r = v << amt;
      MODE_SRL: r = v >> amt;
      MODE_SRA: r = (v >> amt) | fill;
      default:  r = (v >> amt) | (v << back);
    endcase
    return r;
  endfunction

  // Stage 1 state
  logic  s1_valid;
  word_t s1_data;
  logic  [1:0] s1_fine;
  mode_e s1_mode;
  logic  s1_sign;

  // Stage 2 (output) state
  logic  out_valid;
  word_t out_value;
  logic  out_zero;

  // Load enables
  logic  s2_load;
  logic  s1_load;

  // Datapath
  mode_e in_mode;
  amt_t  coarse_amt;
  amt_t  fine_amt;
  word_t s1_next;
  word_t s2_next;

  assign s2_load = !out_valid || sp.OutReady;
  assign s1_load = !s1_valid || s2_load;

  assign in_mode    = mode_e'(sp.Mode);
  assign coarse_amt = {sp.Shamt[SHAMT_W-1:2], 2'b00};
  assign fine_amt   = {{(SHAMT_W-2){1'b0}}, s1_fine};

  assign s1_next = shift_word(sp.ValueIn, coarse_amt, in_mode, sp.ValueIn[DATA_W-1]);
  assign s2_next = shift_word(s1_data, fine_amt, s1_mode, s1_sign);

  assign sp.InReady  = s1_load && !sp.Flush;
  assign sp.OutValid = out_valid;
  assign sp.ValueOut = out_value;
  assign sp.ZeroOut  = out_zero;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_fine   <= '0;
      s1_mode   <= MODE_SLL;
      s1_sign   <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_zero  <= 1'b1;
    end else if (sp.Flush) begin
      // Data registers keep stale contents; only the valids matter.
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_value <= s2_next;
          out_zero  <= (s2_next == '0);
        end
      end
      if (s1_load) begin
        s1_valid <= sp.InValid;
        if (sp.InValid) begin
          s1_data <= s1_next;
          s1_fine <= sp.Shamt[1:0];
          s1_mode <= in_mode;
          s1_sign <= sp.ValueIn[DATA_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed self-checking bench for shift_pipe (DATA_W = 32).
module tb_shift_pipe;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  logic [31:0] tv_in  [16];
  logic [4:0]  tv_sh  [16];
  logic [1:0]  tv_md  [16];
  logic [31:0] tv_exp [16];

  shift_pipe_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  shift_pipe #(.DATA_W(32), .SHAMT_W(5)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .sp      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
    bus.InValid = v;
    bus.ValueIn = d;
    bus.Shamt   = s;
    bus.Mode    = m;
  endtask

  task automatic set_vec(input int i, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] m, input logic [31:0] e);
    tv_in[i]  = d;
    tv_sh[i]  = s;
    tv_md[i]  = m;
    tv_exp[i] = e;
  endtask

  // Back-to-back stream with OutReady high; pipeline must start empty.
  task automatic run_stream(input string name, input int n);
    for (int j = 0; j <= n; j++) begin
      if (j < n) drive(1'b1, tv_in[j], tv_sh[j], tv_md[j]);
      else       drive(1'b0, '0, '0, '0);
      #1;
      if (j < n) check1({name, " inready"}, bus.InReady, 1'b1);
      step();
      if (j == 0) check1({name, " latency"}, bus.OutValid, 1'b0);
      else begin
        check1 ({name, " outvalid"}, bus.OutValid, 1'b1);
        check32({name, " value"},    bus.ValueOut, tv_exp[j-1]);
        check1 ({name, " zero"},     bus.ZeroOut,  tv_exp[j-1] == 32'd0);
      end
    end
    step();
    check1({name, " drained"}, bus.OutValid, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b1;
    drive(1'b0, '0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check1 ("rst outvalid", bus.OutValid, 1'b0);
    check32("rst value",    bus.ValueOut, 32'h0);
    check1 ("rst zero",     bus.ZeroOut,  1'b1);
    rst_n = 1'b1;
    #1;
    check1 ("rst inready",  bus.InReady,  1'b1);
    step();

    // Jump-target style SLL by 2
    set_vec(0, 32'h03FF_FFFF, 5'd2, 2'b00, 32'h0FFF_FFFC);
    run_stream("sll2", 1);

    // Mode sweep, one per cycle
    set_vec(0, 32'h8000_0001, 5'd1, 2'b00, 32'h0000_0002);
    set_vec(1, 32'h8000_0001, 5'd1, 2'b01, 32'h4000_0000);
    set_vec(2, 32'h8000_0001, 5'd1, 2'b10, 32'hC000_0000);
    set_vec(3, 32'h8000_0001, 5'd1, 2'b11, 32'hC000_0000);
    run_stream("sweep", 4);

    // Edge amounts and coarse+fine combinations
    set_vec(0,  32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
    set_vec(1,  32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
    set_vec(2,  32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
    set_vec(3,  32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF);
    set_vec(4,  32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    set_vec(5,  32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    set_vec(6,  32'h0000_0001, 5'd31, 2'b01, 32'h0000_0000);
    set_vec(7,  32'h1234_5678, 5'd5,  2'b11, 32'hC091_A2B3);
    set_vec(8,  32'hF000_0000, 5'd6,  2'b10, 32'hFFC0_0000);
    set_vec(9,  32'hF000_0000, 5'd6,  2'b01, 32'h03C0_0000);
    set_vec(10, 32'h0000_000F, 5'd30, 2'b00, 32'hC000_0000);
    run_stream("edge", 11);

    // Back-pressure
    bus.OutReady = 1'b0;
    drive(1'b1, 32'h0000_0011, 5'd4, 2'b00);
    #1;
    check1 ("bp inready a", bus.InReady, 1'b1);
    step();
    check1 ("bp outvalid a", bus.OutValid, 1'b0);
    drive(1'b1, 32'h0000_0100, 5'd8, 2'b01);
    #1;
    check1 ("bp inready b", bus.InReady, 1'b1);
    step();
    check1 ("bp outvalid", bus.OutValid, 1'b1);
    check32("bp value a",  bus.ValueOut, 32'h0000_0110);
    drive(1'b1, 32'hFFFF_0000, 5'd16, 2'b11);
    #1;
    check1 ("bp full", bus.InReady, 1'b0);
    step();
    check1 ("bp hold valid", bus.OutValid, 1'b1);
    check32("bp hold value", bus.ValueOut, 32'h0000_0110);
    check1 ("bp still full", bus.InReady, 1'b0);
    step();
    check32("bp hold value2", bus.ValueOut, 32'h0000_0110);
    bus.OutReady = 1'b1;
    #1;
    check1 ("bp recovery", bus.InReady, 1'b1);
    step();
    check1 ("bp drain b valid", bus.OutValid, 1'b1);
    check32("bp drain b",       bus.ValueOut, 32'h0000_0001);
    drive(1'b0, '0, '0, '0);
    step();
    check1 ("bp drain c valid", bus.OutValid, 1'b1);
    check32("bp drain c",       bus.ValueOut, 32'h0000_FFFF);
    check1 ("bp drain c zero",  bus.ZeroOut,  1'b0);
    step();
    check1 ("bp empty", bus.OutValid, 1'b0);

    // Flush with both stages full and an input presented
    bus.OutReady = 1'b0;
    drive(1'b1, 32'h0000_0001, 5'd1, 2'b00);
    #1;
    step();
    drive(1'b1, 32'h0000_0008, 5'd3, 2'b01);
    #1;
    step();
    check1 ("fl full valid", bus.OutValid, 1'b1);
    check32("fl full value", bus.ValueOut, 32'h0000_0002);
    drive(1'b1, 32'hCAFE_0000, 5'd4, 2'b00);
    bus.Flush = 1'b1;
    #1;
    check1 ("fl inready", bus.InReady, 1'b0);
    step();
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b1;
    drive(1'b0, '0, '0, '0);
    #1;
    check1 ("fl outvalid", bus.OutValid, 1'b0);
    step();
    check1 ("fl no stale", bus.OutValid, 1'b0);
    drive(1'b1, 32'h0000_FFFF, 5'd3, 2'b10);
    #1;
    check1 ("fl new inready", bus.InReady, 1'b1);
    step();
    check1 ("fl new latency", bus.OutValid, 1'b0);
    drive(1'b0, '0, '0, '0);
    step();
    check1 ("fl new valid", bus.OutValid, 1'b1);
    check32("fl new value", bus.ValueOut, 32'h0000_1FFF);
    step();
    check1 ("fl new drained", bus.OutValid, 1'b0);

    // Asynchronous reset with two operations in flight
    drive(1'b1, 32'hA5A5_A5A5, 5'd4, 2'b11);
    #1;
    step();
    drive(1'b1, 32'h0000_0001, 5'd0, 2'b00);
    #1;
    step();
    check1 ("ar inflight valid", bus.OutValid, 1'b1);
    check32("ar inflight value", bus.ValueOut, 32'h5A5A_5A5A);
    drive(1'b0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check1 ("ar outvalid", bus.OutValid, 1'b0);
    check32("ar value",    bus.ValueOut, 32'h0);
    check1 ("ar zero",     bus.ZeroOut,  1'b1);
    step();
    check1 ("ar held", bus.OutValid, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    check1 ("ar post 1", bus.OutValid, 1'b0);
    step();
    check1 ("ar post 2", bus.OutValid, 1'b0);
    check32("ar post value", bus.ValueOut, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
